// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer
//   Retirement-trace and performance-counter block for the pipelined RISC-V
//   core. Retired register writes from writeback are captured into a circular
//   buffer (wrap or stop-on-full), with an optional register-write trigger
//   followed by a programmable number of post-trigger captures. Event counters
//   and buffer entries are read back through a one-cycle-latency read port.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   clear                      synchronous clear of buffer/counters/state
//   enable, mode_wrap          arm capture; 1 = overwrite oldest when full
//   trig_en, trig_rd           register-write trigger enable / target rd
//   post_count                 captures recorded after the trigger entry
//   wb_enable, wb_rd, wb_data  writeback register write tap
//   stall_if, flush_ex,
//   branch_taken               pipeline events for the counters
//   rd_req, rd_idx             read request, entry index (0 = oldest)
//   rd_valid, rd_entry_rd,
//   rd_entry_data              read response, one cycle after rd_req
//   count, full, triggered,
//   done                       buffer / trigger status
//   cyc_cnt .. br_cnt          saturating event counters
module riscv_trace_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             mode_wrap,
  input  logic             trig_en,
  input  logic [4:0]       trig_rd,
  input  logic [AW:0]      post_count,
  input  logic             wb_enable,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             stall_if,
  input  logic             flush_ex,
  input  logic             branch_taken,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_idx,
  output logic             rd_valid,
  output logic [4:0]       rd_entry_rd,
  output logic [XLEN-1:0]  rd_entry_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             triggered,
  output logic             done,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] br_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [AW:0]      DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0]      CNT1     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      DEPTH_M1 = DEPTH_C - CNT1;
  localparam logic [AW-1:0]    PTR1     = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] EVT1     = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             inc);
    return (inc && (v != '1)) ? v + EVT1 : v;
  endfunction

  // Trace storage (no reset; contents are qualified by count)
  logic [4:0]      mem_rd_q   [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     count_q, count_d;
  logic [AW:0]     remaining_q, remaining_d;
  logic            triggered_q, triggered_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic            rd_valid_q;
  logic [4:0]      rd_entry_rd_q;
  logic [XLEN-1:0] rd_entry_data_q;

  logic            active;
  logic            full_w;
  logic            cap_wr;
  logic            trig_hit;
  logic            fill_done;
  logic            post_done;
  logic            stuck_full;
  logic            finish;
  logic [AW-1:0]   rd_phys;
  logic            rd_in_range;

  assign full_w = (count_q == DEPTH_C);
  assign active = (state_q == S_CAPTURE) || (state_q == S_POST);

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    triggered_d = triggered_q;

    // A full buffer in stop mode accepts nothing further.
    cap_wr     = active && wb_enable && (wb_rd != 5'd0) && (mode_wrap || !full_w);
    trig_hit   = cap_wr && (state_q == S_CAPTURE) && trig_en && (wb_rd == trig_rd);
    fill_done  = cap_wr && !mode_wrap && (count_q == DEPTH_M1);
    post_done  = cap_wr && (state_q == S_POST) && (remaining_q == CNT1);
    // Stop mode selected while already full: nothing more can be recorded.
    stuck_full = active && !mode_wrap && full_w;
    finish     = fill_done || post_done || stuck_full ||
                 (trig_hit && (post_count == '0));

    if (cap_wr) begin
      wptr_d = wptr_q + PTR1;
      if (!full_w) begin
        count_d = count_q + CNT1;
      end
      if (state_q == S_POST) begin
        remaining_d = remaining_q - CNT1;
      end
    end

    if (trig_hit) begin
      triggered_d = 1'b1;
      remaining_d = post_count;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = triggered_q ? S_POST : S_CAPTURE;
        end
      end
      S_CAPTURE, S_POST: begin
        // Completion outranks disarm; a trigger seen while disarming is
        // remembered via triggered_q and resumes into POST.
        if (finish) begin
          state_d = S_DONE;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (trig_hit) begin
          state_d = S_POST;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cyc_d   = sat_inc(cyc_q,   active);
    ret_d   = sat_inc(ret_q,   active && wb_enable);
    stall_d = sat_inc(stall_q, active && stall_if);
    flush_d = sat_inc(flush_q, active && flush_ex);
    br_d    = sat_inc(br_q,    active && branch_taken);
  end

  // Logical index 0 is the oldest entry; count wraps to 0 in AW bits when
  // full, which makes the oldest entry sit at wptr.
  assign rd_phys     = wptr_q - count_q[AW-1:0] + rd_idx;
  assign rd_in_range = ({1'b0, rd_idx} < count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      wptr_q          <= '0;
      count_q         <= '0;
      remaining_q     <= '0;
      triggered_q     <= 1'b0;
      cyc_q           <= '0;
      ret_q           <= '0;
      stall_q         <= '0;
      flush_q         <= '0;
      br_q            <= '0;
      rd_valid_q      <= 1'b0;
      rd_entry_rd_q   <= '0;
      rd_entry_data_q <= '0;
    end else if (clear) begin
      state_q         <= S_IDLE;
      wptr_q          <= '0;
      count_q         <= '0;
      remaining_q     <= '0;
      triggered_q     <= 1'b0;
      cyc_q           <= '0;
      ret_q           <= '0;
      stall_q         <= '0;
      flush_q         <= '0;
      br_q            <= '0;
      rd_valid_q      <= 1'b0;
      rd_entry_rd_q   <= '0;
      rd_entry_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      triggered_q <= triggered_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      br_q        <= br_d;
      rd_valid_q  <= rd_req;
      if (rd_req) begin
        rd_entry_rd_q   <= rd_in_range ? mem_rd_q[rd_phys]   : '0;
        rd_entry_data_q <= rd_in_range ? mem_data_q[rd_phys] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_wr && !clear) begin
      mem_rd_q[wptr_q]   <= wb_rd;
      mem_data_q[wptr_q] <= wb_data;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_entry_rd   = rd_entry_rd_q;
  assign rd_entry_data = rd_entry_data_q;
  assign count         = count_q;
  assign full          = full_w;
  assign triggered     = triggered_q;
  assign done          = (state_q == S_DONE);
  assign cyc_cnt       = cyc_q;
  assign ret_cnt       = ret_q;
  assign stall_cnt     = stall_q;
  assign flush_cnt     = flush_q;
  assign br_cnt        = br_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Testbench for riscv_trace_buffer: directed scenarios plus randomized
// traffic, checked against a queue-based reference model. Read responses are
// checked by a separate monitor from a scoreboard queue.
module tb_riscv_trace_buffer;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             enable;
  logic             mode_wrap;
  logic             trig_en;
  logic [4:0]       trig_rd;
  logic [AW:0]      post_count;
  logic             wb_enable;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             stall_if;
  logic             flush_ex;
  logic             branch_taken;
  logic             rd_req;
  logic [AW-1:0]    rd_idx;
  logic             rd_valid;
  logic [4:0]       rd_entry_rd;
  logic [XLEN-1:0]  rd_entry_data;
  logic [AW:0]      count;
  logic             full;
  logic             triggered;
  logic             done;
  logic [CNT_W-1:0] cyc_cnt, ret_cnt, stall_cnt, flush_cnt, br_cnt;

  riscv_trace_buffer #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .enable       (enable),
    .mode_wrap    (mode_wrap),
    .trig_en      (trig_en),
    .trig_rd      (trig_rd),
    .post_count   (post_count),
    .wb_enable    (wb_enable),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall_if     (stall_if),
    .flush_ex     (flush_ex),
    .branch_taken (branch_taken),
    .rd_req       (rd_req),
    .rd_idx       (rd_idx),
    .rd_valid     (rd_valid),
    .rd_entry_rd  (rd_entry_rd),
    .rd_entry_data(rd_entry_data),
    .count        (count),
    .full         (full),
    .triggered    (triggered),
    .done         (done),
    .cyc_cnt      (cyc_cnt),
    .ret_cnt      (ret_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .br_cnt       (br_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  ent_t        mq[$];      // recorded entries, oldest first
  ent_t        exp_q[$];   // scoreboard of pending read responses
  bit          m_run, m_done, m_trig;
  int          m_rem;
  int unsigned m_cyc, m_ret, m_stall, m_flush, m_br;

  function automatic int unsigned sat(input int unsigned v, input logic inc);
    return (inc && v < CNT_MAX) ? v + 1 : v;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_run = 0; m_done = 0; m_trig = 0; m_rem = 0;
    m_cyc = 0; m_ret = 0; m_stall = 0; m_flush = 0; m_br = 0;
  endfunction

  function automatic ent_t model_read(input logic [AW-1:0] idx);
    ent_t z;
    z = '0;
    if (int'(idx) < mq.size()) return mq[idx];
    return z;
  endfunction

  function automatic void model_edge();
    bit   fin;
    ent_t e;
    if (clear) begin model_reset(); return; end
    if (m_done) return;
    if (!m_run) begin m_run = enable; return; end
    m_cyc   = sat(m_cyc, 1'b1);
    m_ret   = sat(m_ret, wb_enable);
    m_stall = sat(m_stall, stall_if);
    m_flush = sat(m_flush, flush_ex);
    m_br    = sat(m_br, branch_taken);
    fin = 0;
    if (!mode_wrap && mq.size() == DEPTH) begin
      fin = 1;
    end else if (wb_enable && wb_rd != 5'd0) begin
      e.rd = wb_rd; e.data = wb_data;
      mq.push_back(e);
      if (mq.size() > DEPTH) void'(mq.pop_front());
      if (m_trig) begin
        m_rem--;
        if (m_rem == 0) fin = 1;
      end else if (trig_en && wb_rd == trig_rd) begin
        m_trig = 1;
        m_rem  = int'(post_count);
        if (m_rem == 0) fin = 1;
      end
      if (!mode_wrap && mq.size() == DEPTH) fin = 1;
    end
    if (fin) begin m_done = 1; m_run = 0; end
    else m_run = enable;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_all();
    chk("count",     count,     mq.size());
    chk("full",      full,      mq.size() == DEPTH);
    chk("triggered", triggered, m_trig);
    chk("done",      done,      m_done);
    chk("cyc_cnt",   cyc_cnt,   m_cyc);
    chk("ret_cnt",   ret_cnt,   m_ret);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("br_cnt",    br_cnt,    m_br);
  endtask

  task automatic tick();
    ent_t e;
    bit   push;
    push = 0;
    e    = '0;
    if (!clear && rd_req) begin
      push = 1;
      e = model_read(rd_idx);
    end
    model_edge();
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1;
    check_all();
  endtask

  task automatic quiet();
    clear = 0; wb_enable = 0; wb_rd = '0; wb_data = '0;
    stall_if = 0; flush_ex = 0; branch_taken = 0; rd_req = 0; rd_idx = '0;
  endtask

  task automatic do_clear();
    quiet(); enable = 0; clear = 1; tick(); clear = 0;
  endtask

  task automatic retire(input logic [4:0] r, input logic [XLEN-1:0] d);
    wb_enable = 1; wb_rd = r; wb_data = d; tick(); wb_enable = 0;
  endtask

  task automatic read(input logic [AW-1:0] idx);
    rd_req = 1; rd_idx = idx; tick(); rd_req = 0;
  endtask

  // ---------------- read-response monitor ----------------
  ent_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_valid", rd_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (rd_valid) begin
          chk("rd_entry_rd",   rd_entry_rd,   mon_e.rd);
          chk("rd_entry_data", rd_entry_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; enable = 0; mode_wrap = 0; trig_en = 0; trig_rd = '0;
    post_count = '0;
    quiet();
    model_reset();
    #12;
    chk("reset_count", count, 0);
    chk("reset_done",  done, 0);
    chk("reset_rdv",   rd_valid, 0);
    chk("reset_cyc",   cyc_cnt, 0);
    rst_n = 1;
    #4;

    // stop-on-full
    enable = 1; mode_wrap = 0; tick();
    for (int n = 1; n <= 16; n++) retire(5'(n), XLEN'(32'h100 + n));
    chk("t1_done", done, 1);
    chk("t1_count", count, 16);
    retire(5'd17, 32'h111);
    chk("t1_count17", count, 16);
    read('0);
    chk("t1_rd0_rd", rd_entry_rd, 1);
    chk("t1_rd0_data", rd_entry_data, 32'h101);
    tick();

    // wrap mode
    do_clear();
    enable = 1; mode_wrap = 1; tick();
    for (int n = 1; n <= 20; n++) retire(5'(n % 32), XLEN'(n));
    chk("t2_count", count, 16);
    chk("t2_full", full, 1);
    chk("t2_done", done, 0);
    read(4'd0);
    chk("t2_idx0", rd_entry_data, 5);
    read(4'd15);
    chk("t2_idx15", rd_entry_data, 20);
    tick();

    // trigger with post-count
    do_clear();
    mode_wrap = 0; trig_en = 1; trig_rd = 5'd7; post_count = 3;
    enable = 1; tick();
    for (int r = 5; r <= 11; r++) begin
      retire(5'(r), XLEN'(r));
      if (r == 7)  chk("t3_trig", triggered, 1);
      if (r == 9)  chk("t3_notdone", done, 0);
      if (r == 10) chk("t3_done", done, 1);
    end
    chk("t3_count", count, 6);
    read(4'd5);
    chk("t3_last", rd_entry_rd, 10);
    tick();

    // event counters: 10 enabled cycles
    do_clear();
    trig_en = 0; enable = 1; tick();
    for (int i = 0; i < 10; i++) begin
      enable       = (i < 9);
      wb_enable    = (i == 0 || i == 2 || i == 4 || i == 6);
      wb_rd        = (i == 6) ? 5'd0 : 5'(i + 1);
      wb_data      = XLEN'(i);
      stall_if     = (i == 1 || i == 3);
      flush_ex     = (i == 5);
      branch_taken = (i == 2 || i == 7 || i == 8);
      tick();
    end
    quiet(); tick();
    chk("t4_cyc", cyc_cnt, 10);
    chk("t4_ret", ret_cnt, 4);
    chk("t4_stall", stall_cnt, 2);
    chk("t4_flush", flush_cnt, 1);
    chk("t4_br", br_cnt, 3);
    chk("t4_count", count, 3);

    // async reset mid-capture, then clear against a capture
    do_clear();
    enable = 1; mode_wrap = 1; tick();
    retire(5'd3, 32'hAA); retire(5'd4, 32'hBB);
    read(4'd1); tick();
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("t5_count", count, 0);
    chk("t5_cyc", cyc_cnt, 0);
    chk("t5_ret", ret_cnt, 0);
    chk("t5_rdv", rd_valid, 0);
    chk("t5_erd", rd_entry_rd, 0);
    chk("t5_edata", rd_entry_data, 0);
    #2 rst_n = 1;
    tick();
    clear = 1; wb_enable = 1; wb_rd = 5'd3; wb_data = 32'h55; tick();
    quiet();
    chk("t5_clr_count", count, 0);
    chk("t5_clr_ret", ret_cnt, 0);

    // out-of-range read
    enable = 1; tick();
    for (int n = 1; n <= 4; n++) retire(5'(n), XLEN'(n));
    read(4'd9);
    chk("t6_rdv", rd_valid, 1);
    chk("t6_rd", rd_entry_rd, 0);
    chk("t6_data", rd_entry_data, 0);
    tick();
    chk("t6_rdv_low", rd_valid, 0);

    // randomized traffic
    do_clear();
    for (int i = 0; i < 500; i++) begin
      clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) mode_wrap = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        trig_en    = 1'($urandom_range(0, 1));
        trig_rd    = 5'($urandom_range(1, 7));
        post_count = (AW+1)'($urandom_range(0, 6));
      end
      wb_enable    = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 7));
      wb_data      = $urandom();
      stall_if     = 1'($urandom_range(0, 1));
      flush_ex     = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 2) == 0);
      rd_req       = ($urandom_range(0, 2) == 0);
      rd_idx       = AW'($urandom_range(0, DEPTH - 1));
      tick();
    end

    // counter saturation
    do_clear();
    enable = 1; mode_wrap = 1; trig_en = 0;
    for (int i = 0; i < 300; i++) begin
      wb_enable = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 31));
      wb_data   = $urandom();
      stall_if  = 1;
      rd_req    = ($urandom_range(0, 3) == 0);
      rd_idx    = AW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    quiet(); enable = 0; tick(); tick();
    chk("sat_cyc", cyc_cnt, CNT_MAX);
    chk("sat_stall", stall_cnt, CNT_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
Synthesizable retirement-trace and performance-counter block for the pipelined RISC-V CPU. It taps the writeback stage and hazard/branch signals. Retired register writes (rd, data) are captured into a parametrised circular buffer, with wrap or stop-on-full modes and an optional register-write trigger with post-trigger depth. Event counters and the buffer are read back through a one-cycle-latency read port, replacing per-cycle display-based pipeline inspection.

Parameters:
XLEN, 32, data width of wb_data and trace entries
DEPTH, 16, trace entries; power of 2, >=2; AW = clog2(DEPTH)
CNT_W, 32, width of each event counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of buffer, counters and state; highest priority
enable  in  1  arm capture
mode_wrap  in  1  1 = overwrite oldest when full; 0 = stop when full
trig_en  in  1  enable register-write trigger
trig_rd  in  5  trigger destination register
post_count  in  AW+1  captures recorded after the trigger entry
wb_enable  in  1  writeback register write this cycle
wb_rd  in  5  writeback destination
wb_data  in  XLEN  writeback data
stall_if  in  1  IF stall event
flush_ex  in  1  EX flush event
branch_taken  in  1  taken-branch event
rd_req  in  1  read request
rd_idx  in  AW  entry index, 0 = oldest
rd_valid  out  1  read data valid, one cycle after rd_req
rd_entry_rd  out  5  entry destination register
rd_entry_data  out  XLEN  entry data
count  out  AW+1  valid entries, 0..DEPTH
full  out  1  count == DEPTH
triggered  out  1  trigger has fired
done  out  1  state == DONE
cyc_cnt, ret_cnt, stall_cnt, flush_cnt, br_cnt  out  CNT_W each  event counters

Behaviour:
- Reset (rst_n low, async) and clear: state IDLE; write pointer 0; count 0; all counters 0; triggered 0; rd_valid 0; rd_entry_* 0. Buffer contents need not be cleared.
- States: IDLE, CAPTURE, POST, DONE.
  - IDLE->CAPTURE when enable=1.
  - CAPTURE/POST->IDLE when enable=0. Contents, counters and the remaining post count are held. Re-enable resumes CAPTURE, or POST if triggered=1.
  - DONE is left only by clear or reset. enable is ignored in DONE.
- Capture event = state in {CAPTURE, POST} and wb_enable=1 and wb_rd!=0. The entry {wb_rd, wb_data} is written at wptr, and wptr increments mod DEPTH. count increments and saturates at DEPTH.
- Full, mode_wrap=1: the capture overwrites the oldest entry; count stays DEPTH.
- Full, mode_wrap=0: the capture that makes count==DEPTH moves the state to DONE the next cycle. No further writes occur.
- Trigger: in CAPTURE with trig_en=1, a capture with wb_rd==trig_rd records the entry and sets triggered=1.
  - If post_count==0: go to DONE.
  - Otherwise: go to POST with remaining=post_count.
  - In POST, each capture decrements remaining. The capture that brings it to 0 is recorded and moves the state to DONE.
  - In POST, stop-on-full still applies.
- Counters increment only in CAPTURE/POST and saturate at 2^CNT_W-1:
  - cyc_cnt: every cycle.
  - ret_cnt: on wb_enable, including rd=0.
  - stall_cnt: on stall_if.
  - flush_cnt: on flush_ex.
  - br_cnt: on branch_taken.
  - The cycle that enters DONE is still counted.
- Read port:
  - rd_req sampled at edge N. At N+1, rd_valid=1 with the entry at physical index (wptr - count + rd_idx) mod DEPTH; rd_valid is otherwise 0.
  - rd_idx >= count returns rd_entry_rd=0 and rd_entry_data=0 with rd_valid=1.
  - Read and capture at the same edge: the read uses pre-edge wptr, count and contents.
  - Reads work in every state.
- Simultaneous clear and capture: clear wins; nothing is recorded.

Test Plan:
- Reset, enable=1, mode_wrap=0, DEPTH=16; retire x1..x16 with data 0x100+n -> done=1 after the 16th; count=16; read idx0 -> rd=1, data=0x101; a 17th retire is not recorded.
- mode_wrap=1; retire 20 writes x1..x20 (rd=n mod 32), data n -> count=16, full=1; idx0 data=5; idx15 data=20; done=0.
- trig_en=1, trig_rd=7, post_count=3; retire x5,x6,x7,x8,x9,x10,x11 -> triggered=1 at x7; done after x10; count=6; x11 not recorded.
- 10 enabled cycles with 4 wb_enable (one with rd=0), 2 stall_if, 1 flush_ex, 3 branch_taken -> cyc=10, ret=4, stall=2, flush=1, br=3, count=3.
- Mid-capture: assert rst_n=0 asynchronously between edges -> all outputs zero immediately. Then assert clear with a simultaneous wb_enable -> count=0, ret_cnt=0.
- rd_req with rd_idx=9 while count=4 -> next cycle rd_valid=1, rd_entry_rd=0, rd_entry_data=0; rd_valid=0 the following cycle.
